// File: rtl/lsu_pkg.sv
// Shared constants and state type for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational helpers: access legality, store lane/strobe placement, load lane extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] raw,
  output logic        legal,
  output logic [3:0]  wstrb,
  output logic [31:0] wlanes,
  output logic [31:0] ldata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    legal  = 1'b0;
    wstrb  = 4'b0000;
    wlanes = wdata;
    case (funct3)
      F3_B: begin
        legal  = 1'b1;
        wstrb  = 4'b0001 << offset;
        wlanes = {4{wdata[7:0]}};
      end
      F3_H: begin
        legal  = ~offset[0];
        wstrb  = 4'b0011 << offset;
        wlanes = {2{wdata[15:0]}};
      end
      F3_W: begin
        legal = (offset == 2'b00);
        wstrb = 4'b1111;
      end
      F3_BU:   legal = ~write;
      F3_HU:   legal = ~write & ~offset[0];
      default: legal = 1'b0;
    endcase
    // Loads never drive strobes, whatever the size code.
    if (!write) wstrb = 4'b0000;
  end

  always_comb begin
    lane_b = raw[{ld_offset, 3'b000} +: 8];
    lane_h = ld_offset[1] ? raw[31:16] : raw[15:0];
    case (ld_funct3)
      F3_B:    ldata = {{24{lane_b[7]}}, lane_b};
      F3_H:    ldata = {{16{lane_h[15]}}, lane_h};
      F3_BU:   ldata = {24'd0, lane_b};
      F3_HU:   ldata = {16'd0, lane_h};
      default: ldata = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns core memory ops into word-aligned valid/ready bus transactions.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] TMO = TIMEOUT[15:0];

  lsu_state_t  state, state_next;
  logic [15:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        legal;
  logic [3:0]  strb;
  logic [31:0] lanes;
  logic [31:0] ldata;
  logic        timeout_hit;

  lsu_align u_align (
    .write     (req_write),
    .funct3    (funct3),
    .offset    (addr[1:0]),
    .wdata     (wdata),
    .ld_funct3 (f3_q),
    .ld_offset (off_q),
    .raw       (mem_rdata),
    .legal     (legal),
    .wstrb     (strb),
    .wlanes    (lanes),
    .ldata     (ldata)
  );

  // The count is compared one ahead so the abort lands on the TIMEOUT-th idle BUSY cycle.
  assign timeout_hit = (TMO != 16'd0) && ((cnt + 16'd1) == TMO);

  assign rdata = (state == FAULT) ? 32'd0 : rdata_q;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) state_next = legal ? BUSY : FAULT;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ready)        state_next = DONE;
        else if (timeout_hit) state_next = FAULT;
      end
      DONE:  state_next = IDLE;
      FAULT: begin
        fault      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rdata_q   <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid && legal) begin
            mem_req   <= 1'b1;
            mem_we    <= req_write;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= req_write ? lanes : 32'd0;
            mem_wstrb <= strb;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            cnt       <= 16'd0;
          end
        end
        BUSY: begin
          // Bus fields stay frozen; only the request line and load result move here.
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata_q <= ldata;
          end else begin
            cnt <= cnt + 16'd1;
            if (timeout_hit) mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: spec-level transaction model checked every cycle.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  bit check_en = 1'b0;

  logic        exp_stall, exp_fault, exp_req, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] last_rdata = 32'd0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Access size in bytes implied by a funct3 code; 0 marks an undefined code.
  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int sz = model_size(f3);
    if (sz == 0) return 0;
    if (wr && f3 > 3'd2) return 0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int sz = model_size(f3);
    longint v = (longint'(word) >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
    if (f3 < 3'd4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz = model_size(f3);
    int m = ((1 << sz) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (model_size(f3))
      1:       return (w & 32'hFF) * 32'h01010101;
      2:       return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // Per-cycle compare against the model's expectations.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("stall", {31'd0, stall}, {31'd0, exp_stall});
      checkOutput("fault", {31'd0, fault}, {31'd0, exp_fault});
      checkOutput("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      checkOutput("rdata", rdata, exp_rdata);
      if (exp_req) begin
        checkOutput("mem_addr", mem_addr, exp_addr);
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        checkOutput("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
      end
      if (stall) stall_cnt++;
    end
  end

  // One core operation; delay = idle BUSY cycles before mem_ready, negative = never ready.
  task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] word, input int delay);
    bit ok = model_legal(wr, f3, a);
    bit done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd; mem_ready = 1'b0;
    exp_stall = 1'b1; exp_fault = 1'b0; exp_req = 1'b0; exp_rdata = last_rdata;
    exp_addr = a & ~32'd3; exp_we = wr;
    exp_wstrb = wr ? model_strb(f3, a) : 4'b0000;
    exp_wdata = model_wdata(f3, wd);
    if (ok) begin
      for (int i = 0; i < TMO && !done; i++) begin
        @(posedge clk); #1;
        exp_req = 1'b1;
        mem_ready = (i == delay);
        mem_rdata = mem_ready ? word : 32'hDEAD_BEEF;
        done = mem_ready;
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b0; req_valid = 1'b0; mem_rdata = 32'h0BAD_F00D;
    exp_stall = 1'b0; exp_req = 1'b0;
    if (done) begin
      if (!wr) last_rdata = model_load(f3, a, word);
      exp_rdata = last_rdata;
      exp_fault = 1'b0;
    end else begin
      exp_rdata = 32'd0;
      exp_fault = 1'b1;
    end
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
    exp_stall = 1'b0; exp_fault = 1'b0; exp_req = 1'b0; exp_rdata = last_rdata;
  endtask

  initial begin
    exp_stall = 1'b0; exp_fault = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_rdata = 32'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_wstrb = 4'd0;

    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    idleCycle();

    // Model pins against hand-computed values.
    checkOutput("model_lb", model_load(F3_B, 32'h102, 32'h1280FF00), 32'hFFFFFF80);
    checkOutput("model_lbu", model_load(F3_BU, 32'h102, 32'h1280FF00), 32'h00000080);
    checkOutput("model_lh", model_load(F3_H, 32'h102, 32'h1280FF00), 32'h00001280);
    checkOutput("model_sb_strb", {28'd0, model_strb(F3_B, 32'h203)}, 32'h8);

    stall_cnt = 0;
    applyStimulus(1'b0, F3_W, 32'h100, 32'd0, 32'h89ABCDEF, 1);
    checkOutput("lw_rdata", rdata, 32'h89ABCDEF);
    checkOutput("lw_stall_cycles", stall_cnt, 32'd3);

    applyStimulus(1'b1, F3_B, 32'h203, 32'h000000A5, 32'd0, 0);
    checkOutput("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
    checkOutput("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    checkOutput("sb_we", {31'd0, mem_we}, 32'd1);
    checkOutput("sb_keeps_rdata", rdata, 32'h89ABCDEF);

    applyStimulus(1'b0, F3_B, 32'h102, 32'd0, 32'h1280FF00, 0);
    checkOutput("lb_rdata", rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, F3_BU, 32'h102, 32'd0, 32'h1280FF00, 1);
    checkOutput("lbu_rdata", rdata, 32'h00000080);
    applyStimulus(1'b0, F3_H, 32'h102, 32'd0, 32'h1280FF00, 0);
    checkOutput("lh_rdata", rdata, 32'h00001280);
    applyStimulus(1'b0, F3_HU, 32'h102, 32'd0, 32'h80010000, 0);
    applyStimulus(1'b0, F3_H, 32'h100, 32'd0, 32'h00008001, 2);
    applyStimulus(1'b0, F3_B, 32'h101, 32'd0, 32'h00007F00, 0);

    applyStimulus(1'b1, F3_W, 32'h202, 32'h11111111, 32'd0, 0);
    applyStimulus(1'b0, F3_H, 32'h101, 32'd0, 32'd0, 0);
    applyStimulus(1'b1, 3'b011, 32'h200, 32'h1, 32'd0, 0);
    applyStimulus(1'b1, F3_BU, 32'h200, 32'h1, 32'd0, 0);
    applyStimulus(1'b0, 3'b110, 32'h200, 32'd0, 32'd0, 0);
    idleCycle();

    applyStimulus(1'b1, F3_H, 32'h202, 32'h0000_1234, 32'd0, 2);
    applyStimulus(1'b1, F3_W, 32'h204, 32'hCAFEBABE, 32'd0, 1);

    applyStimulus(1'b0, F3_W, 32'h300, 32'd0, 32'd0, -1);
    idleCycle();
    applyStimulus(1'b0, F3_W, 32'h304, 32'd0, 32'h5555AAAA, TMO - 1);
    checkOutput("ready_at_timeout", rdata, 32'h5555AAAA);

    // Reset lands while a load is waiting on the bus.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; funct3 = F3_W; addr = 32'h400; mem_ready = 1'b0;
    exp_stall = 1'b1; exp_fault = 1'b0; exp_req = 1'b0; exp_rdata = last_rdata;
    exp_addr = 32'h400; exp_we = 1'b0; exp_wstrb = 4'b0000;
    @(posedge clk); #1;
    exp_req = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    last_rdata = 32'd0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0; exp_rdata = 32'd0;
    checkOutput("rst_busy_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, F3_W, 32'h100, 32'd0, 32'h11223344, 0);
    checkOutput("lw_after_reset", rdata, 32'h11223344);
    idleCycle();
    idleCycle();
    @(posedge clk); #1;
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
